// File: rtl/sap_pkg.sv
// Shared definitions for the SAP core: opcodes, control-word bit map,
// sequencer state encodings and a small control-word helper.
package sap_pkg;

  localparam int OPW    = 4;
  localparam int CTRL_W = 16;

  // Opcodes carried in IR[7:4]
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit indices
  localparam logic [3:0] CTRL_PC_INC   = 4'd0;
  localparam logic [3:0] CTRL_PC_OUT   = 4'd1;
  localparam logic [3:0] CTRL_JUMP     = 4'd2;
  localparam logic [3:0] CTRL_MAR_IN   = 4'd3;
  localparam logic [3:0] CTRL_RAM_IN   = 4'd4;
  localparam logic [3:0] CTRL_RAM_OUT  = 4'd5;
  localparam logic [3:0] CTRL_IR_IN    = 4'd6;
  localparam logic [3:0] CTRL_IR_OUT   = 4'd7;
  localparam logic [3:0] CTRL_A_IN     = 4'd8;
  localparam logic [3:0] CTRL_A_LO_IN  = 4'd9;
  localparam logic [3:0] CTRL_A_OUT    = 4'd10;
  localparam logic [3:0] CTRL_B_IN     = 4'd11;
  localparam logic [3:0] CTRL_SUB      = 4'd12;
  localparam logic [3:0] CTRL_ALU_OUT  = 4'd13;
  localparam logic [3:0] CTRL_FLAG_IN  = 4'd14;
  localparam logic [3:0] CTRL_OUT_IN   = 4'd15;

  // Sequencer states; the encoding doubles as the t_state debug value
  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_HALT = 3'd6,
    S_RST  = 3'd7
  } state_t;

  // One-hot control word with only bit idx set
  function automatic logic [CTRL_W-1:0] ctrl_bit(input logic [3:0] idx);
    logic [CTRL_W-1:0] v;
    v = {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (state, opcode, flags) -> control word, last-step
// marker and halt. Only one bus driver is ever enabled in any row.
module sap_microcode_rom
  import sap_pkg::*;
(
  input  state_t            i_state,
  input  logic [OPW-1:0]    i_opcode,
  input  logic              i_flag_c,
  input  logic              i_flag_z,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_last_step,
  output logic              o_halt
);

  // Decode the current microstep; unlisted opcodes fall through to NOP rows
  always_comb begin
    o_ctrl      = {CTRL_W{1'b0}};
    o_last_step = 1'b0;
    o_halt      = 1'b0;
    case (i_state)
      S_T0: begin
        o_ctrl = ctrl_bit(CTRL_PC_OUT) | ctrl_bit(CTRL_MAR_IN);
      end
      S_T1: begin
        o_ctrl = ctrl_bit(CTRL_RAM_OUT) | ctrl_bit(CTRL_IR_IN) | ctrl_bit(CTRL_PC_INC);
      end
      S_T2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_ctrl = ctrl_bit(CTRL_IR_OUT) | ctrl_bit(CTRL_MAR_IN);
          end
          OP_LDI: begin
            o_ctrl      = ctrl_bit(CTRL_IR_OUT) | ctrl_bit(CTRL_A_LO_IN);
            o_last_step = 1'b1;
          end
          OP_JMP: begin
            o_ctrl      = ctrl_bit(CTRL_IR_OUT) | ctrl_bit(CTRL_JUMP);
            o_last_step = 1'b1;
          end
          OP_JC: begin
            if (i_flag_c) begin
              o_ctrl = ctrl_bit(CTRL_IR_OUT) | ctrl_bit(CTRL_JUMP);
            end else begin
              o_ctrl = ctrl_bit(CTRL_IR_OUT);
            end
            o_last_step = 1'b1;
          end
          OP_JZ: begin
            if (i_flag_z) begin
              o_ctrl = ctrl_bit(CTRL_IR_OUT) | ctrl_bit(CTRL_JUMP);
            end else begin
              o_ctrl = ctrl_bit(CTRL_IR_OUT);
            end
            o_last_step = 1'b1;
          end
          OP_OUT: begin
            o_ctrl      = ctrl_bit(CTRL_A_OUT) | ctrl_bit(CTRL_OUT_IN);
            o_last_step = 1'b1;
          end
          OP_HLT: begin
            // Enables stay off; the sequencer parks in S_HALT on halt
            o_halt = 1'b1;
          end
          default: begin
            // NOP and undefined opcodes 0x9-0xD
            o_last_step = 1'b1;
          end
        endcase
      end
      S_T3: begin
        case (i_opcode)
          OP_LDA: begin
            o_ctrl      = ctrl_bit(CTRL_RAM_OUT) | ctrl_bit(CTRL_A_IN);
            o_last_step = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_ctrl = ctrl_bit(CTRL_RAM_OUT) | ctrl_bit(CTRL_B_IN);
          end
          OP_STA: begin
            o_ctrl      = ctrl_bit(CTRL_A_OUT) | ctrl_bit(CTRL_RAM_IN);
            o_last_step = 1'b1;
          end
          default: begin
            // Not reachable for a stable opcode; end the instruction safely
            o_last_step = 1'b1;
          end
        endcase
      end
      S_T4: begin
        case (i_opcode)
          OP_ADD: begin
            o_ctrl = ctrl_bit(CTRL_ALU_OUT) | ctrl_bit(CTRL_A_IN) | ctrl_bit(CTRL_FLAG_IN);
          end
          OP_SUB: begin
            o_ctrl = ctrl_bit(CTRL_ALU_OUT) | ctrl_bit(CTRL_A_IN) | ctrl_bit(CTRL_FLAG_IN)
                   | ctrl_bit(CTRL_SUB);
          end
          default: begin
            o_ctrl = {CTRL_W{1'b0}};
          end
        endcase
        o_last_step = 1'b1;
      end
      S_HALT: begin
        o_halt = 1'b1;
      end
      S_RST: begin
        o_ctrl = {CTRL_W{1'b0}};
      end
      default: begin
        // Unused encoding: no enables, return to fetch
        o_last_step = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: T-state register plus next-state mux around the
// microcode ROM. ctrl/halt are combinational from state, opcode and flags.
module sap_control_sequencer #(
  parameter int OPW    = 4,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CTRL_W-1:0] ctrl,
  output logic              halt,
  output logic [2:0]        t_state
);

  import sap_pkg::*;

  state_t            r_state;
  state_t            w_next_state;
  logic [CTRL_W-1:0] w_ctrl;
  logic              w_last_step;
  logic              w_halt;

  sap_microcode_rom u_rom (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_flag_c    (flag_c),
    .i_flag_z    (flag_z),
    .o_ctrl      (w_ctrl),
    .o_last_step (w_last_step),
    .o_halt      (w_halt)
  );

  // State register; reset forces S_RST so every enable drops immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection: halt wins, then last step returns to fetch
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RST:  w_next_state = S_T0;
      S_T0:   w_next_state = S_T1;
      S_T1:   w_next_state = S_T2;
      S_T2: begin
        if (w_halt) begin
          w_next_state = S_HALT;
        end else if (w_last_step) begin
          w_next_state = S_T0;
        end else begin
          w_next_state = S_T3;
        end
      end
      S_T3: begin
        if (w_last_step) begin
          w_next_state = S_T0;
        end else begin
          w_next_state = S_T4;
        end
      end
      S_T4:   w_next_state = S_T0;
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_RST;
    endcase
  end

  assign ctrl    = w_ctrl;
  assign halt    = w_halt;
  assign t_state = r_state;

endmodule
